// File: rtl/counter_rr_sched.sv
// rtl/counter_rr_sched.sv - round-robin sequencer sharing one up-counter between NREQ requesters
//
// Purpose: grants a WIDTH-bit up-counter to one requester at a time,
//   counts q = 0..len-1 for that requester, then pulses done for one cycle.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   req    in   [NREQ]        request per requester, held until done
//   len    in   [NREQ*WIDTH]  run length per requester, slice i = len[i*WIDTH +: WIDTH]
//   grant  out  [NREQ]        one-hot owner of the counter, 0 when idle
//   q      out  [WIDTH]       shared counter value
//   busy   out                high whenever a run is owned (RUN or DONE)
//   done   out  [NREQ]        one-cycle completion pulse for the owner
// Option: CNT_RR_ABORT_EN - when defined, the owner dropping req during RUN
//   aborts the run (back to IDLE, no done, rr_ptr untouched).

module counter_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic [NREQ-1:0]       done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    rr_ptr, rr_ptr_n;
  logic [WIDTH-1:0] len_lat, len_lat_n;
  logic [WIDTH-1:0] q_n;
  logic [NREQ-1:0]  grant_n;

  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;
  int               sum;
  logic [WIDTH-1:0] win_len;

  // Round-robin search: first set request starting at rr_ptr, wrapping mod NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = 0;
    idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum = int'(rr_ptr) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Constant-index mux of the winner's length slice.
  always_comb begin
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) win_len = len[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    q_n       = q;
    len_lat_n = len_lat;
    rr_ptr_n  = rr_ptr;
    case (state)
      IDLE: begin
        q_n     = '0;
        grant_n = '0;
        if (found) begin
          grant_n[win] = 1'b1;
          len_lat_n    = win_len;
          // Move past the winner so it becomes lowest priority next time.
          rr_ptr_n     = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          state_n      = (win_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Last count is len_lat-1; q then holds through DONE, so it never wraps.
        if (q == len_lat - 1'b1) state_n = DONE;
        else                     q_n     = q + 1'b1;
`ifdef CNT_RR_ABORT_EN
        if ((req & grant) == '0) begin
          state_n = IDLE;
          grant_n = '0;
          q_n     = '0;
        end
`endif
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        q_n     = '0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        q_n     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      q       <= '0;
      len_lat <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      q       <= q_n;
      len_lat <= len_lat_n;
      rr_ptr  <= rr_ptr_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) ? grant : '0;

endmodule
